// File: rtl/sobel_edge_3x3.sv
// 3x3 Sobel edge detector over three buffered RGB888 line streams.
// Four-stage pipeline: gray conversion, window shift, gradients, magnitude/threshold.
module sobel_edge_3x3 #(
  parameter int DataWidth  = 24,
  parameter int XADRSWidth = 11
) (
  input  logic                 RCK,
  input  logic                 RESET,
  input  logic                 REN,
  input  logic                 HSTART,
  input  logic [DataWidth-1:0] RD0,
  input  logic [DataWidth-1:0] RD1,
  input  logic [DataWidth-1:0] RD2,
  input  logic                 THR_EN,
  input  logic [7:0]           THRESH,
  output logic [DataWidth-1:0] DOUT,
  output logic                 DVALID
);

  localparam logic [XADRSWidth-1:0] ColMax = '1;

  // Gray = (77R + 150G + 29B) >> 8; the 16-bit sum cannot overflow (max 255*256).
  function automatic logic [7:0] to_gray(input logic [DataWidth-1:0] p);
    logic [15:0] s;
    s = 16'd77 * 16'(p[23:16]) + 16'd150 * 16'(p[15:8]) + 16'd29 * 16'(p[7:0]);
    return s[15:8];
  endfunction

  // 1-2-1 weighted sum of three gray samples, range 0..1020.
  function automatic logic [10:0] ksum(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    return 11'(a) + (11'(b) << 1) + 11'(c);
  endfunction

  // Valid shift register: [0]=stage 1 ... [3]=output stage.
  logic [3:0]            vld_pipe_q;
  logic                  hs1_q;
  // Row index: 0 = top (RD2), 1 = middle (RD1), 2 = bottom (RD0).
  logic [2:0][7:0]       y1_q;
  // win_q[row][col], col 2 is the newest column.
  logic [2:0][2:0][7:0]  win_q, win_d;
  logic [XADRSWidth-1:0] col_q, col_d;
  logic                  line_act_q, line_act_d;
  logic                  full2_q, full2_d;
  logic                  full3_q;
  logic signed [10:0]    gx_q, gy_q, gx_d, gy_d;
  logic [DataWidth-1:0]  dout_q;
  logic [7:0]            res_d;

  // Valid pipeline; reset discards every beat in flight.
  always_ff @(posedge RCK) begin
    if (RESET) vld_pipe_q <= '0;
    else       vld_pipe_q <= {vld_pipe_q[2:0], REN};
  end

  // Stage 1: per-row gray conversion and line-start flag.
  always_ff @(posedge RCK) begin
    if (RESET) begin
      hs1_q <= 1'b0;
      y1_q  <= '0;
    end else begin
      hs1_q   <= HSTART;
      y1_q[0] <= to_gray(RD2);
      y1_q[1] <= to_gray(RD1);
      y1_q[2] <= to_gray(RD0);
    end
  end

  // Stage 2 next state: window shift, column count and border flag on valid beats only.
  always_comb begin
    win_d      = win_q;
    col_d      = col_q;
    line_act_d = line_act_q;
    full2_d    = full2_q;
    if (vld_pipe_q[0]) begin
      for (int r = 0; r < 3; r++) win_d[r] = {y1_q[r], win_q[r][2:1]};
      if (hs1_q) begin
        col_d      = XADRSWidth'(1);
        line_act_d = 1'b1;
      end else if (col_q != ColMax) begin
        col_d = col_q + XADRSWidth'(1);
      end
      // Until an HSTART has been seen since reset every output is a border pixel.
      full2_d = line_act_d && !hs1_q && (col_d >= XADRSWidth'(3));
    end
  end

  // Stage 2 registers.
  always_ff @(posedge RCK) begin
    if (RESET) begin
      win_q      <= '0;
      col_q      <= '0;
      line_act_q <= 1'b0;
      full2_q    <= 1'b0;
    end else begin
      win_q      <= win_d;
      col_q      <= col_d;
      line_act_q <= line_act_d;
      full2_q    <= full2_d;
    end
  end

  // Stage 3 gradients: Gx = right - left column, Gy = bottom - top row.
  always_comb begin
    gx_d = $signed(ksum(win_q[0][2], win_q[1][2], win_q[2][2]))
         - $signed(ksum(win_q[0][0], win_q[1][0], win_q[2][0]));
    gy_d = $signed(ksum(win_q[2][0], win_q[2][1], win_q[2][2]))
         - $signed(ksum(win_q[0][0], win_q[0][1], win_q[0][2]));
  end

  // Stage 3 registers.
  always_ff @(posedge RCK) begin
    if (RESET) begin
      gx_q    <= '0;
      gy_q    <= '0;
      full3_q <= 1'b0;
    end else begin
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      full3_q <= full2_q;
    end
  end

  // Stage 4 result: |Gx|+|Gy|, saturated or binarized, zero on border pixels.
  always_comb begin
    logic [10:0] ax, ay;
    logic [11:0] mag;
    ax  = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
    ay  = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
    mag = 12'(ax) + 12'(ay);
    res_d = '0;
    if (full3_q) begin
      if (THR_EN)             res_d = (mag >= 12'(THRESH)) ? 8'hFF : 8'h00;
      else if (mag > 12'd255) res_d = 8'hFF;
      else                    res_d = mag[7:0];
    end
  end

  // Output register holds its value between valid beats.
  always_ff @(posedge RCK) begin
    if (RESET)              dout_q <= '0;
    else if (vld_pipe_q[2]) dout_q <= DataWidth'({res_d, res_d, res_d});
  end

  assign DOUT   = dout_q;
  assign DVALID = vld_pipe_q[3];

endmodule

// File: tb/tb_sobel_edge_3x3.sv
// Directed bench for sobel_edge_3x3 with a queue scoreboard fed by a line-buffer model.
module tb_sobel_edge_3x3;

  logic        RCK = 1'b0;
  logic        RESET, REN, HSTART, THR_EN;
  logic [23:0] RD0, RD1, RD2;
  logic [7:0]  THRESH;
  logic [23:0] DOUT;
  logic        DVALID;

  sobel_edge_3x3 #(.DataWidth(24), .XADRSWidth(11)) dut (
    .RCK(RCK), .RESET(RESET), .REN(REN), .HSTART(HSTART),
    .RD0(RD0), .RD1(RD1), .RD2(RD2), .THR_EN(THR_EN), .THRESH(THRESH),
    .DOUT(DOUT), .DVALID(DVALID)
  );

  always #5 RCK = ~RCK;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [23:0] exp_q[$];
  int          cyc_q[$];
  // Model line store: gray value per row (0 top/RD2, 1 mid/RD1, 2 bottom/RD0) and column.
  int          gl[3][2048];
  int          col = -1;
  logic [23:0] last_dout = '0;
  bit          prev_rst = 1'b1;

  always @(posedge RCK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic int gray(input logic [23:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected result for the beat just stored at column c of the model line.
  function automatic logic [23:0] expect_at(input int c);
    int gx, gy, mag;
    logic [7:0] r;
    if (c < 2) return 24'h0;
    gx = (gl[0][c] + 2 * gl[1][c] + gl[2][c]) - (gl[0][c-2] + 2 * gl[1][c-2] + gl[2][c-2]);
    gy = (gl[2][c-2] + 2 * gl[2][c-1] + gl[2][c]) - (gl[0][c-2] + 2 * gl[0][c-1] + gl[0][c]);
    mag = iabs(gx) + iabs(gy);
    if (THR_EN) r = (mag >= int'(THRESH)) ? 8'hFF : 8'h00;
    else        r = (mag > 255) ? 8'hFF : 8'(mag);
    return {r, r, r};
  endfunction

  task automatic idle(input int n);
    REN = 1'b0; HSTART = 1'b0;
    repeat (n) begin @(posedge RCK); #1; end
  endtask

  // One input beat; the expected output is queued with its due cycle.
  task automatic beat(input bit hs, input logic [23:0] p0, input logic [23:0] p1,
                      input logic [23:0] p2);
    logic [23:0] e;
    if (hs)           col = 0;
    else if (col >= 0) col++;
    e = 24'h0;
    if (col >= 0 && col < 2048) begin
      gl[0][col] = gray(p2);
      gl[1][col] = gray(p1);
      gl[2][col] = gray(p0);
      e = expect_at(col);
    end
    exp_q.push_back(e);
    cyc_q.push_back(cyc + 4);
    REN = 1'b1; HSTART = hs; RD0 = p0; RD1 = p1; RD2 = p2;
    @(posedge RCK); #1;
    REN = 1'b0; HSTART = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1; REN = 1'b0; HSTART = 1'b0;
    @(posedge RCK); #1;
    RESET = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    col = -1;
  endtask

  task automatic vert_line(input bit gapped);
    logic [23:0] p;
    for (int c = 0; c < 16; c++) begin
      p = (c < 8) ? 24'h000000 : 24'hFFFFFF;
      beat(c == 0, p, p, p);
      if (gapped) idle($urandom_range(1, 3));
    end
  endtask

  task automatic rand_line(input int len, input int restart_at);
    for (int c = 0; c < len; c++)
      beat(c == 0 || c == restart_at, 24'($urandom), 24'($urandom), 24'($urandom));
  endtask

  // Output monitor: pops the scoreboard on DVALID, otherwise checks that DOUT holds.
  always @(negedge RCK) begin
    logic [23:0] e;
    int ec;
    if (DVALID === 1'b1) begin
      chk("dvalid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        chk("dout", 32'(DOUT), 32'(e));
        chk("latency_cycle", 32'(cyc), 32'(ec));
      end
    end else if (!prev_rst) begin
      chk("dout_hold", 32'(DOUT), 32'(last_dout));
    end
    last_dout = DOUT;
    prev_rst  = RESET;
  end

  initial begin
    RESET = 1'b1; REN = 1'b1; HSTART = 1'b1; THR_EN = 1'b0; THRESH = 8'h00;
    RD0 = 24'hFFFFFF; RD1 = 24'h000000; RD2 = 24'h123456;
    // Outputs stay cleared while reset is held, even with REN asserted.
    repeat (3) begin
      @(posedge RCK); #1;
      chk("reset_dout", 32'(DOUT), 32'h0);
      chk("reset_dvalid", 32'(DVALID), 32'h0);
    end
    RESET = 1'b0; REN = 1'b0; HSTART = 1'b0;
    idle(2);

    // Flat field: no gradient anywhere.
    for (int c = 0; c < 16; c++) beat(c == 0, 24'h808080, 24'h808080, 24'h808080);
    idle(8);

    // Vertical edge, back to back.
    vert_line(1'b0);
    idle(8);

    // Horizontal edge, magnitude then binarized.
    for (int c = 0; c < 16; c++) beat(c == 0, 24'hFFFFFF, 24'hFFFFFF, 24'h000000);
    idle(8);
    THR_EN = 1'b1; THRESH = 8'h40;
    for (int c = 0; c < 16; c++) beat(c == 0, 24'hFFFFFF, 24'hFFFFFF, 24'h000000);
    idle(8);

    // Random images, binarized then magnitude, to exercise threshold and saturation.
    THRESH = 8'($urandom_range(20, 200));
    rand_line(20, -1);
    idle(8);
    THR_EN = 1'b0;
    rand_line(20, -1);
    idle(8);

    // Low-contrast ramp: unsaturated magnitudes.
    for (int c = 0; c < 12; c++)
      beat(c == 0, 24'(c * 24'h030303), 24'(c * 24'h020202), 24'(c * 24'h010101));
    idle(8);

    // Vertical edge with random REN gaps.
    vert_line(1'b1);
    idle(8);

    // HSTART arriving mid-line restarts the column count.
    rand_line(16, 6);
    idle(8);

    // Mid-line reset at column 5, stray beats before HSTART, then a fresh line.
    rand_line(5, -1);
    do_reset();
    idle(3);
    beat(1'b0, 24'hFFFFFF, 24'h000000, 24'h000000);
    beat(1'b0, 24'hFFFFFF, 24'hFFFFFF, 24'h000000);
    beat(1'b0, 24'h000000, 24'hFFFFFF, 24'hFFFFFF);
    idle(2);
    rand_line(14, -1);
    idle(10);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
